// File: rtl/packet_tx_framer_if.sv
// Transmit word bus between the framer and the radio/CSMA stage.
// master drives tx_data/tx_valid/tx_last, slave drives tx_ready.
interface packet_tx_framer_if #(
  parameter int WORD_WIDTH = 16
);
  logic [WORD_WIDTH-1:0] tx_data;
  logic                  tx_valid;
  logic                  tx_last;
  logic                  tx_ready;

  modport master (
    output tx_data,
    output tx_valid,
    output tx_last,
    input  tx_ready
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    input  tx_last,
    output tx_ready
  );
endinterface

// File: rtl/packet_tx_framer.sv
// Captures reward-block fields and streams header, payload, XOR checksum.
// Ports: clk/rst, reward_done+r* fields in, tx bus (master), busy,
// pkt_sent, drop_pulse, drop_count out.
module packet_tx_framer #(
  parameter int WORD_WIDTH = 16,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WORD_WIDTH-1:0] reward_done,
  input  logic [2:0]            rPacketType,
  input  logic [WORD_WIDTH-1:0] rSourceID,
  input  logic [WORD_WIDTH-1:0] rEnergyLeft,
  input  logic [WORD_WIDTH-1:0] rQValue,
  input  logic [WORD_WIDTH-1:0] rSourceHops,
  input  logic [WORD_WIDTH-1:0] rDestinationID,
  input  logic [WORD_WIDTH-1:0] rChosenCH,
  input  logic [WORD_WIDTH-1:0] rHopsFromCH,
  packet_tx_framer_if.master    tx,
  output logic                  busy,
  output logic                  pkt_sent,
  output logic                  drop_pulse,
  output logic [CNT_WIDTH-1:0]  drop_count
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_HDR,
    S_PAY,
    S_CHK
  } state_t;

  // Shadow field slots
  localparam logic [2:0] F_SRC = 3'd0;
  localparam logic [2:0] F_EN  = 3'd1;
  localparam logic [2:0] F_Q   = 3'd2;
  localparam logic [2:0] F_SH  = 3'd3;
  localparam logic [2:0] F_DST = 3'd4;
  localparam logic [2:0] F_CCH = 3'd5;
  localparam logic [2:0] F_HCH = 3'd6;

  state_t                      state_q, state_d;
  logic [2:0]                  type_q, type_d;
  logic [6:0][WORD_WIDTH-1:0]  fld_q, fld_d;
  logic [2:0]                  idx_q, idx_d;
  logic [WORD_WIDTH-1:0]       chk_q, chk_d;
  logic [WORD_WIDTH-1:0]       data_q, data_d;
  logic                        valid_q, valid_d;
  logic                        last_q, last_d;
  logic                        sent_q, sent_d;
  logic                        drop_q, drop_d;
  logic [CNT_WIDTH-1:0]        cnt_q, cnt_d;

  logic                        strobe;
  logic                        hs;
  logic [7:0]                  len_w;
  logic [2:0]                  last_idx;
  logic [2:0]                  nxt_idx;
  logic [WORD_WIDTH-1:0]       acc;
  logic                        unused_rd;

  assign unused_rd = ^reward_done[WORD_WIDTH-1:1];

  function automatic logic [7:0] frame_len(input logic [2:0] t);
    case (t)
      3'b000:  frame_len = 8'd2;
      3'b010:  frame_len = 8'd3;
      3'b011:  frame_len = 8'd4;
      3'b100:  frame_len = 8'd2;
      3'b101:  frame_len = 8'd5;
      3'b110:  frame_len = 8'd5;
      default: frame_len = 8'd0;
    endcase
  endfunction

  function automatic logic [2:0] pay_field(
    input logic [2:0] t,
    input logic [2:0] i
  );
    pay_field = F_SRC;
    case (t)
      3'b000: if (i == 3'd1) pay_field = F_SH;
      3'b010:
        case (i)
          3'd1:    pay_field = F_CCH;
          3'd2:    pay_field = F_HCH;
          default: ;
        endcase
      3'b011:
        case (i)
          3'd1:    pay_field = F_DST;
          3'd2:    pay_field = F_EN;
          3'd3:    pay_field = F_Q;
          default: ;
        endcase
      3'b100: if (i == 3'd1) pay_field = F_DST;
      default:
        case (i)
          3'd1:    pay_field = F_DST;
          3'd2:    pay_field = F_EN;
          3'd3:    pay_field = F_Q;
          3'd4:    pay_field = F_SH;
          default: ;
        endcase
    endcase
  endfunction

  function automatic logic [WORD_WIDTH-1:0] hdr_word(input logic [2:0] t);
    hdr_word = '0;
    hdr_word[WORD_WIDTH-1 -: 3] = t;
    hdr_word[7:0] = frame_len(t);
  endfunction

  assign strobe = reward_done[0] &&
                  (rPacketType != 3'b001) &&
                  (rPacketType != 3'b111);
  assign hs       = valid_q && tx.tx_ready;
  assign len_w    = frame_len(type_q);
  assign last_idx = len_w[2:0] - 3'd1;
  assign nxt_idx  = idx_q + 3'd1;
  // Running checksum including the word being handed over now
  assign acc      = chk_q ^ data_q;

  always_comb begin
    state_d = state_q;
    type_d  = type_q;
    fld_d   = fld_q;
    idx_d   = idx_q;
    chk_d   = chk_q;
    data_d  = data_q;
    sent_d  = 1'b0;
    drop_d  = 1'b0;
    cnt_d   = cnt_q;

    unique case (state_q)
      S_IDLE: begin
        data_d = '0;
        if (strobe) begin
          type_d         = rPacketType;
          fld_d[F_SRC]   = rSourceID;
          fld_d[F_EN]    = rEnergyLeft;
          fld_d[F_Q]     = rQValue;
          fld_d[F_SH]    = rSourceHops;
          fld_d[F_DST]   = rDestinationID;
          fld_d[F_CCH]   = rChosenCH;
          fld_d[F_HCH]   = rHopsFromCH;
          chk_d          = '0;
          idx_d          = '0;
          data_d         = hdr_word(rPacketType);
          state_d        = S_HDR;
        end
      end
      S_HDR: begin
        if (hs) begin
          chk_d   = acc;
          idx_d   = '0;
          data_d  = fld_q[pay_field(type_q, 3'd0)];
          state_d = S_PAY;
        end
      end
      S_PAY: begin
        if (hs) begin
          chk_d = acc;
          if (idx_q == last_idx) begin
            data_d  = acc;
            state_d = S_CHK;
          end else begin
            idx_d  = nxt_idx;
            data_d = fld_q[pay_field(type_q, nxt_idx)];
          end
        end
      end
      S_CHK: begin
        if (hs) begin
          data_d  = '0;
          sent_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
    endcase

    // Refusals never touch the in-flight frame
    if (strobe && (state_q != S_IDLE)) begin
      drop_d = 1'b1;
      if (cnt_q != '1) cnt_d = cnt_q + CNT_WIDTH'(1);
    end

    valid_d = (state_d != S_IDLE);
    last_d  = (state_d == S_CHK);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      type_q  <= '0;
      fld_q   <= '0;
      idx_q   <= '0;
      chk_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      sent_q  <= 1'b0;
      drop_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      type_q  <= type_d;
      fld_q   <= fld_d;
      idx_q   <= idx_d;
      chk_q   <= chk_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      sent_q  <= sent_d;
      drop_q  <= drop_d;
      cnt_q   <= cnt_d;
    end
  end

  assign tx.tx_data  = data_q;
  assign tx.tx_valid = valid_q;
  assign tx.tx_last  = last_q;
  assign busy        = valid_q;
  assign pkt_sent    = sent_q;
  assign drop_pulse  = drop_q;
  assign drop_count  = cnt_q;

endmodule

// File: tb/tb_packet_tx_framer.sv
// Bench for packet_tx_framer: table vectors, corner sequences,
// random frames against a field-list reference model.
module tb_packet_tx_framer;
  localparam int W = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [W-1:0]  reward_done;
  logic [2:0]    rPacketType;
  logic [W-1:0]  rSourceID, rEnergyLeft, rQValue, rSourceHops;
  logic [W-1:0]  rDestinationID, rChosenCH, rHopsFromCH;
  logic          busy, pkt_sent, drop_pulse;
  logic [7:0]    drop_count;

  packet_tx_framer_if #(.WORD_WIDTH(W)) tx_if ();

  packet_tx_framer #(.WORD_WIDTH(W), .CNT_WIDTH(8)) dut (
    .clk           (clk),
    .rst           (rst),
    .reward_done   (reward_done),
    .rPacketType   (rPacketType),
    .rSourceID     (rSourceID),
    .rEnergyLeft   (rEnergyLeft),
    .rQValue       (rQValue),
    .rSourceHops   (rSourceHops),
    .rDestinationID(rDestinationID),
    .rChosenCH     (rChosenCH),
    .rHopsFromCH   (rHopsFromCH),
    .tx            (tx_if),
    .busy          (busy),
    .pkt_sent      (pkt_sent),
    .drop_pulse    (drop_pulse),
    .drop_count    (drop_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]       t;
    logic [15:0]      src, en, q, sh, dst, cch, hch;
    logic [3:0]       n;
    logic [6:0][15:0] w;
  } vec_t;

  vec_t         tbl[$];
  logic [15:0]  exp_q[$];
  int           nvec = 0;
  int           nfail = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    nvec++;
    if (act !== req) begin
      nfail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, req, $time);
    end
  endtask

  task automatic add_vec(input logic [2:0] t,
      input logic [15:0] src, en, q, sh, dst, cch, hch,
      input int n,
      input logic [15:0] w0, w1, w2, w3, w4, w5, w6);
    vec_t v;
    v.t = t; v.src = src; v.en = en; v.q = q; v.sh = sh;
    v.dst = dst; v.cch = cch; v.hch = hch; v.n = 4'(n);
    v.w[0] = w0; v.w[1] = w1; v.w[2] = w2; v.w[3] = w3;
    v.w[4] = w4; v.w[5] = w5; v.w[6] = w6;
    tbl.push_back(v);
  endtask

  task automatic set_fields(input logic [2:0] t,
      input logic [15:0] src, en, q, sh, dst, cch, hch);
    rPacketType = t; rSourceID = src; rEnergyLeft = en; rQValue = q;
    rSourceHops = sh; rDestinationID = dst; rChosenCH = cch;
    rHopsFromCH = hch;
  endtask

  // One-cycle strobe; returns in the cycle the header should appear
  task automatic strobe();
    reward_done = W'($urandom) | W'(1);
    tick();
    reward_done = '0;
  endtask

  // Reference: frame built straight from per-type field lists
  task automatic model_frame(input logic [2:0] t,
      input logic [15:0] src, en, q, sh, dst, cch, hch);
    logic [15:0] pay[$];
    logic [15:0] h, x;
    pay = {};
    case (t)
      3'd0: begin pay.push_back(src); pay.push_back(sh); end
      3'd2: begin pay.push_back(src); pay.push_back(cch);
                  pay.push_back(hch); end
      3'd3: begin pay.push_back(src); pay.push_back(dst);
                  pay.push_back(en);  pay.push_back(q); end
      3'd4: begin pay.push_back(src); pay.push_back(dst); end
      default: begin pay.push_back(src); pay.push_back(dst);
                  pay.push_back(en); pay.push_back(q);
                  pay.push_back(sh); end
    endcase
    h = {t, 5'b0, 8'(pay.size())};
    x = h;
    exp_q = {};
    exp_q.push_back(h);
    foreach (pay[i]) begin
      exp_q.push_back(pay[i]);
      x = x ^ pay[i];
    end
    exp_q.push_back(x);
  endtask

  // mode 0: ready always 1; 1: random ready; 2: 3 stalls on word 2
  task automatic collect(input int mode, input bit strobe_last);
    int k = 0;
    int cyc = 0;
    int stalls = 0;
    int n;
    bit stalled = 0;
    logic [15:0] held = '0;
    logic rdy;
    n = exp_q.size();
    while (k < n && cyc < 200) begin
      if (stalled) begin
        chk("hold_data", 32'(tx_if.tx_data), 32'(held));
        chk("hold_valid", 32'(tx_if.tx_valid), 32'd1);
      end
      case (mode)
        0: rdy = 1'b1;
        1: rdy = ($urandom_range(0, 3) != 0);
        default: begin
          rdy = !(k == 2 && stalls < 3);
          if (!rdy) stalls++;
        end
      endcase
      tx_if.tx_ready = rdy;
      if (mode == 0) chk("valid_run", 32'(tx_if.tx_valid), 32'd1);
      if (tx_if.tx_valid && rdy) begin
        chk($sformatf("word%0d", k), 32'(tx_if.tx_data), 32'(exp_q[k]));
        chk("last", 32'(tx_if.tx_last), 32'(k == n - 1));
        if (strobe_last && k == n - 1) reward_done = W'(1);
        k++;
        stalled = 0;
      end else if (tx_if.tx_valid) begin
        stalled = 1;
        held = tx_if.tx_data;
      end
      tick();
      cyc++;
    end
    reward_done = '0;
    if (k < n) begin
      nfail++;
      $display("FAIL timeout: got %0d words expected %0d", k, n);
    end
    chk("pkt_sent", 32'(pkt_sent), 32'd1);
    chk("busy_end", 32'(busy), 32'd0);
    if (strobe_last) chk("drop_on_chk", 32'(drop_pulse), 32'd1);
  endtask

  task automatic run_vec(input vec_t v, input int mode);
    set_fields(v.t, v.src, v.en, v.q, v.sh, v.dst, v.cch, v.hch);
    exp_q = {};
    for (int k = 0; k < int'(v.n); k++) exp_q.push_back(v.w[k]);
    strobe();
    collect(mode, 1'b0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_data"}, 32'(tx_if.tx_data), 32'd0);
    chk({tag, "_valid"}, 32'(tx_if.tx_valid), 32'd0);
    chk({tag, "_last"}, 32'(tx_if.tx_last), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_sent"}, 32'(pkt_sent), 32'd0);
    chk({tag, "_drop"}, 32'(drop_pulse), 32'd0);
    chk({tag, "_cnt"}, 32'(drop_count), 32'd0);
  endtask

  initial begin
    logic [2:0] types [6];
    logic [2:0] rt;
    logic [15:0] f [7];
    bit sl;

    types[0] = 3'd0; types[1] = 3'd2; types[2] = 3'd3;
    types[3] = 3'd4; types[4] = 3'd5; types[5] = 3'd6;

    add_vec(3'd0, 16'h0005, 16'h0, 16'h0, 16'h0003, 16'h0, 16'h0, 16'h0,
            4, 16'h0002, 16'h0005, 16'h0003, 16'h0004, 0, 0, 0);
    add_vec(3'd5, 16'h0007, 16'h0100, 16'h0010, 16'h0003, 16'h0002,
            16'h0, 16'h0, 7, 16'hA005, 16'h0007, 16'h0002, 16'h0100,
            16'h0010, 16'h0003, 16'hA113);
    add_vec(3'd6, 16'h1111, 16'h4444, 16'h8888, 16'h000F, 16'h2222,
            16'h0, 16'h0, 7, 16'hC005, 16'h1111, 16'h2222, 16'h4444,
            16'h8888, 16'h000F, 16'h3FF5);
    add_vec(3'd2, 16'h0A0A, 16'h0, 16'h0, 16'h0, 16'h0, 16'h00C0,
            16'h0002, 5, 16'h4003, 16'h0A0A, 16'h00C0, 16'h0002,
            16'h4ACB, 0, 0);
    add_vec(3'd3, 16'h0001, 16'h0004, 16'h0008, 16'h0, 16'h0002, 16'h0,
            16'h0, 6, 16'h6004, 16'h0001, 16'h0002, 16'h0004,
            16'h0008, 16'h600B, 0);
    add_vec(3'd4, 16'hFFFF, 16'h0, 16'h0, 16'h0, 16'h0F0F, 16'h0, 16'h0,
            4, 16'h8002, 16'hFFFF, 16'h0F0F, 16'h70F2, 0, 0, 0);

    rst = 1'b1;
    reward_done = '0;
    tx_if.tx_ready = 1'b0;
    set_fields(3'd0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    tick();
    check_reset_outputs("reset");
    rst = 1'b0;
    tick();

    foreach (tbl[i]) run_vec(tbl[i], 0);

    // Stall: word 2 of the Data frame held for 4 cycles
    run_vec(tbl[1], 2);

    // Untransmittable types and a strobe with bit 0 clear
    tx_if.tx_ready = 1'b1;
    set_fields(3'd1, 16'h1, 16'h1, 16'h1, 16'h1, 16'h1, 16'h1, 16'h1);
    reward_done = W'(1);
    tick();
    rPacketType = 3'd7;
    tick();
    rPacketType = 3'd0;
    reward_done = 16'hFFFE;
    tick();
    reward_done = '0;
    chk("ign_valid", 32'(tx_if.tx_valid), 32'd0);
    chk("ign_busy", 32'(busy), 32'd0);
    chk("ign_cnt", 32'(drop_count), 32'd0);
    chk("ign_drop", 32'(drop_pulse), 32'd0);

    // Refusal during INV frame with changed inputs
    set_fields(3'd2, 16'h0A0A, 0, 0, 0, 0, 16'h00C0, 16'h0002);
    model_frame(3'd2, 16'h0A0A, 0, 0, 0, 0, 16'h00C0, 16'h0002);
    strobe();
    tx_if.tx_ready = 1'b0;
    set_fields(3'd3, 16'hDEAD, 16'hBEEF, 16'h1234, 16'h5678, 16'h9ABC,
               16'hDEF0, 16'h0F0F);
    reward_done = W'(1);
    tick();
    reward_done = '0;
    chk("drop_pulse", 32'(drop_pulse), 32'd1);
    chk("drop_cnt1", 32'(drop_count), 32'd1);
    collect(0, 1'b0);
    chk("drop_once", 32'(drop_pulse), 32'd0);

    // Saturation of drop_count during a stalled HB frame
    set_fields(3'd0, 16'h0005, 0, 0, 16'h0003, 0, 0, 0);
    model_frame(3'd0, 16'h0005, 0, 0, 16'h0003, 0, 0, 0);
    strobe();
    tx_if.tx_ready = 1'b0;
    reward_done = W'(1);
    for (int i = 0; i < 253; i++) tick();
    chk("drop_cnt_fe", 32'(drop_count), 32'hFE);
    tick();
    tick();
    chk("drop_cnt_ff", 32'(drop_count), 32'hFF);
    reward_done = '0;
    tick();
    chk("drop_cnt_sat", 32'(drop_count), 32'hFF);
    collect(0, 1'b0);

    // Reset mid-payload of an MR frame, strobe also asserted
    set_fields(3'd3, 16'h0001, 16'h0004, 16'h0008, 0, 16'h0002, 0, 0);
    strobe();
    tx_if.tx_ready = 1'b1;
    tick();
    tick();
    chk("mr_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    rPacketType = 3'd0;
    reward_done = W'(1);
    tick();
    rst = 1'b0;
    reward_done = '0;
    check_reset_outputs("midrst");
    tick();
    chk("midrst_nosent", 32'(pkt_sent), 32'd0);
    chk("midrst_idle", 32'(busy), 32'd0);
    run_vec(tbl[0], 0);

    // Random frames, random ready, back-to-back and refusal on checksum
    for (int fr = 0; fr < 40; fr++) begin
      rt = types[$urandom_range(0, 5)];
      foreach (f[i]) f[i] = 16'($urandom);
      set_fields(rt, f[0], f[1], f[2], f[3], f[4], f[5], f[6]);
      model_frame(rt, f[0], f[1], f[2], f[3], f[4], f[5], f[6]);
      sl = ($urandom_range(0, 3) == 0);
      strobe();
      collect(1, sl);
      tx_if.tx_ready = 1'($urandom);
      for (int g = $urandom_range(0, 2); g > 0; g--) tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/packet_tx_framer.md
# packet_tx_framer

Downstream stage of the reward block. Captures the packed fields (`rPacketType`, `rSourceID`, `rEnergyLeft`, `rQValue`, `rSourceHops`, `rDestinationID`, `rChosenCH`, `rHopsFromCH`) when `reward_done` fires. Serializes them into a framed word stream on a valid/ready transmit bus: header, then type-dependent payload, then XOR checksum. This stream feeds the radio/CSMA transmit interface.

## Interface
- `WORD_WIDTH`, 16: width of every field and of `tx_data`; must be ≥ 16.
- `CNT_WIDTH`, 8: width of `drop_count`.

Ports:
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `reward_done` in WORD_WIDTH: capture strobe; only bit 0 is used.
- `rPacketType` in 3: packet type from the reward block.
- `rSourceID`, `rEnergyLeft`, `rQValue`, `rSourceHops`, `rDestinationID`, `rChosenCH`, `rHopsFromCH` in WORD_WIDTH each: packet fields.
- `tx_ready` in 1: downstream accepts the current word.
- `tx_data` out WORD_WIDTH: current frame word.
- `tx_valid` out 1: `tx_data` is valid.
- `tx_last` out 1: current word is the checksum (last word of the frame).
- `busy` out 1: a frame is held or in flight.
- `pkt_sent` out 1: one-cycle pulse after the checksum handshake.
- `drop_pulse` out 1: one-cycle pulse when a capture is refused.
- `drop_count` out CNT_WIDTH: number of refused captures; saturates at all-ones.

## Operation
- States:
  - `S_IDLE`: waiting for a capture.
  - `S_HDR`: presenting the header.
  - `S_PAY`: presenting payload words.
  - `S_CHK`: presenting the checksum.
- Capture condition: `reward_done[0]`=1 in `S_IDLE` with a transmittable type.
  - On capture, latch all eight inputs into shadow registers, clear the checksum accumulator and the payload index, and go to `S_HDR`.
  - Types 001 (CHE) and 111 (invalid) are not transmittable. They are silently ignored: no drop, no state change.
- Payload order per type (L = number of payload words):
  - 000 HB: SourceID, SourceHops (L=2).
  - 010 INV: SourceID, ChosenCH, HopsFromCH (L=3).
  - 011 MR: SourceID, DestinationID, EnergyLeft, QValue (L=4).
  - 100 CHT: SourceID, DestinationID (L=2).
  - 101 Data and 110 SOS: SourceID, DestinationID, EnergyLeft, QValue, SourceHops (L=5).
- Header word:
  - bits [WORD_WIDTH-1 -: 3] = type.
  - bits [7:0] = L.
  - all other bits = 0.
- Checksum = XOR of the header and all L payload words.
  - Accumulate on each handshake of a header or payload word.
- Word handshake: a word is transferred when `tx_valid`=1 and `tx_ready`=1 in the same cycle.
  - `S_HDR` → `S_PAY` on handshake.
  - In `S_PAY`, increment the index on each handshake. After handshake of index L-1, go to `S_CHK`.
  - `S_CHK` → `S_IDLE` on handshake; `pkt_sent`=1 in the following cycle.
- Refused capture: `reward_done[0]`=1 with a transmittable type while not in `S_IDLE`.
  - Pulse `drop_pulse` in the next cycle.
  - Increment `drop_count`, saturating.
  - The in-flight frame is unaffected; shadow registers never change mid-frame.
- Outputs:
  - `tx_valid` = 1 in `S_HDR`, `S_PAY` and `S_CHK` only.
  - `busy` = 1 when the state is not `S_IDLE`.
  - `tx_last` = 1 only in `S_CHK`.

## Timing
- Reset values: state `S_IDLE`; `tx_data`=0, `tx_valid`=0, `tx_last`=0, `busy`=0, `pkt_sent`=0, `drop_pulse`=0, `drop_count`=0.
  - `rst` overrides every other input in the same edge.
  - Reset mid-frame abandons the frame with no `pkt_sent`.
- Capture at edge t gives header valid in cycle t+1.
  - With `tx_ready` held 1, a frame occupies L+2 consecutive cycles.
  - `pkt_sent` and `busy`=0 both occur in the cycle after the checksum handshake.
- Stall: while `tx_valid`=1 and `tx_ready`=0, `tx_data`, `tx_last` and the state are held stable. `tx_valid` never drops before its handshake.
- A strobe in the same cycle as the checksum handshake is refused (state is `S_CHK`). The earliest accepted capture is the cycle after the checksum handshake, i.e. back-to-back frames have a 1-cycle bubble.
- Outputs are registered; `tx_data` has no combinational path from `tx_ready`.
- `tx_ready` asserted in `S_IDLE` has no effect.

## Test plan
- HB capture, type 000, SourceID=0x0005, SourceHops=0x0003, `tx_ready`=1 → words 0x0002, 0x0005, 0x0003, 0x0004 (`tx_last` on 0x0004) in cycles t+1..t+4; `pkt_sent` at t+5.
- Data capture, type 101, Src=0x0007, Dest=0x0002, Energy=0x0100, Q=0x0010, Hops=0x0003 → 0xA005, 0x0007, 0x0002, 0x0100, 0x0010, 0x0003, 0xA113.
- Same Data frame with `tx_ready` low for 3 cycles on word 2 → 0x0002 held for 4 cycles with `tx_valid`=1; remaining sequence unchanged.
- Strobe with type 001, then with type 111 → no `tx_valid`, `busy`=0, `drop_count`=0.
- Strobe during an in-flight INV frame with the input fields changed → `drop_pulse` once, `drop_count`=1, INV frame words unchanged. With 255 more refusals, `drop_count` stays at 0xFF.
- `rst` asserted during `S_PAY` of an MR frame → next cycle all outputs at reset values; a fresh HB capture afterwards produces a correct frame.
